vote_decoder_tally: RTL and testbench



---
 rtl/vote_decoder_tally.sv | 102 ++++++++++
 tb/tb_vote_decoder_tally.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vote_decoder_tally.sv
// Ballot-unit receiver: arms once per ballot, accepts one encoded vote, lights the
// candidate lamp for a fixed time and keeps saturating per-candidate tallies.
module vote_decoder_tally #(
   parameter int CNT_W       = 8,
   parameter int SHOW_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ballot_en,
   input  logic             valid,
   input  logic [3:0]       code,
   output logic             busy,
   output logic             ready,
   output logic             vote_strobe,
   output logic [15:0]      vote_onehot,
   input  logic [3:0]       rd_sel,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W+3:0] total_votes,
   output logic             overflow
);

   localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ARMED   = 3'd1;
   localparam logic [2:0] CAST    = 3'd2;
   localparam logic [2:0] SHOW    = 3'd3;
   localparam logic [2:0] RELEASE = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [3:0]       code_q, code_d;
   logic [SW-1:0]    showCnt_q, showCnt_d;
   logic [CNT_W-1:0] cnt_q [16];
   logic [CNT_W+3:0] total_q;
   logic             overflow_q, overflow_d;

   logic [CNT_W-1:0] selCnt;
   logic             cntFull;
   logic             totFull;

   assign selCnt  = cnt_q[code_q];
   assign cntFull = &selCnt;
   assign totFull = &total_q;

   // Arming requires a released keypad so a button held before arming cannot vote.
   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      showCnt_d  = showCnt_q;
      overflow_d = overflow_q;
      case (state_q)
         IDLE:    if (ballot_en && !valid) state_d = ARMED;
         ARMED:   if (valid) begin
                     code_d  = code;
                     state_d = CAST;
                  end
         CAST:    begin
                     showCnt_d = SW'(SHOW_CYCLES - 1);
                     state_d   = SHOW;
                     if (cntFull || totFull) overflow_d = 1'b1;
                  end
         SHOW:    if (showCnt_q == '0) state_d = RELEASE;
                  else showCnt_d = showCnt_q - SW'(1);
         RELEASE: if (!valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         code_q     <= '0;
         showCnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         showCnt_q  <= showCnt_d;
         overflow_q <= overflow_d;
      end
   end

   // Both tallies bump on the edge that closes CAST, each held at all-ones once full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
         total_q <= '0;
      end else if (state_q == CAST) begin
         if (!cntFull) cnt_q[code_q] <= selCnt + CNT_W'(1);
         if (!totFull) total_q <= total_q + (CNT_W+4)'(1);
      end
   end

   assign ready       = (state_q == ARMED);
   assign busy        = !ready;
   assign vote_strobe = (state_q == CAST);
   assign vote_onehot = ((state_q == CAST) || (state_q == SHOW)) ? (16'h0001 << code_q) : 16'h0000;
   assign rd_count    = cnt_q[rd_sel];
   assign total_votes = total_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_vote_decoder_tally.sv
// Directed bench for vote_decoder_tally: per-cycle vector table for the main flow plus
// hand-written sequences for saturation (narrow counters) and asynchronous reset.
module tb_vote_decoder_tally;

   typedef struct {
      logic        ben;
      logic        val;
      logic [3:0]  code;
      logic [3:0]  sel;
      logic        ready;
      logic        strobe;
      logic [15:0] oh;
      logic [7:0]  cnt;
      logic [11:0] tot;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ballotEn = 1'b0, valid = 1'b0;
   logic [3:0]  code = '0, rdSel = '0;
   logic        busy, ready, voteStrobe, overflow;
   logic [15:0] voteOnehot;
   logic [7:0]  rdCount;
   logic [11:0] totalVotes;

   logic        ballotEn2 = 1'b0, valid2 = 1'b0;
   logic [3:0]  code2 = '0, rdSel2 = '0;
   logic        busy2, ready2, voteStrobe2, overflow2;
   logic [15:0] voteOnehot2;
   logic [1:0]  rdCount2;
   logic [5:0]  totalVotes2;

   int checks = 0;
   int fails  = 0;

   vec_t vecs [29];

   always #5 clk = ~clk;

   vote_decoder_tally #(.CNT_W(8), .SHOW_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .ballot_en(ballotEn), .valid(valid), .code(code),
      .busy(busy), .ready(ready), .vote_strobe(voteStrobe), .vote_onehot(voteOnehot),
      .rd_sel(rdSel), .rd_count(rdCount), .total_votes(totalVotes), .overflow(overflow)
   );

   vote_decoder_tally #(.CNT_W(2), .SHOW_CYCLES(4)) dutNarrow (
      .clk(clk), .rst_n(rst_n), .ballot_en(ballotEn2), .valid(valid2), .code(code2),
      .busy(busy2), .ready(ready2), .vote_strobe(voteStrobe2), .vote_onehot(voteOnehot2),
      .rd_sel(rdSel2), .rd_count(rdCount2), .total_votes(totalVotes2), .overflow(overflow2)
   );

   function automatic vec_t mkVec(logic ben, logic val, logic [3:0] c, logic [3:0] s,
                                  logic rdy, logic stb, logic [15:0] oh,
                                  logic [7:0] cnt, logic [11:0] tot);
      vec_t v;
      v.ben = ben; v.val = val; v.code = c; v.sel = s;
      v.ready = rdy; v.strobe = stb; v.oh = oh; v.cnt = cnt; v.tot = tot;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one vector at the falling edge, then sample just after the rising edge.
   task automatic applyStimulus(input vec_t v, input int idx);
      @(negedge clk);
      ballotEn = v.ben; valid = v.val; code = v.code; rdSel = v.sel;
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d.ready", idx),  {31'd0, ready},      {31'd0, v.ready});
      checkOutput($sformatf("v%0d.busy", idx),   {31'd0, busy},       {31'd0, !v.ready});
      checkOutput($sformatf("v%0d.strobe", idx), {31'd0, voteStrobe}, {31'd0, v.strobe});
      checkOutput($sformatf("v%0d.onehot", idx), {16'd0, voteOnehot}, {16'd0, v.oh});
      checkOutput($sformatf("v%0d.rdCount", idx),{24'd0, rdCount},    {24'd0, v.cnt});
      checkOutput($sformatf("v%0d.total", idx),  {20'd0, totalVotes}, {20'd0, v.tot});
   endtask

   task automatic castNarrow(input logic [3:0] c);
      @(negedge clk); ballotEn2 = 1'b1; valid2 = 1'b0;
      @(negedge clk); ballotEn2 = 1'b0; valid2 = 1'b1; code2 = c;
      @(negedge clk); valid2 = 1'b0;
      repeat (7) @(negedge clk);
   endtask

   initial begin
      // Vote for 5; lamp on for CAST plus four SHOW cycles.
      vecs[0]  = mkVec(1, 0, 4'd0,  4'd5,  1, 0, 16'h0000, 8'd0, 12'd0);
      vecs[1]  = mkVec(0, 1, 4'd5,  4'd5,  0, 1, 16'h0020, 8'd0, 12'd0);
      vecs[2]  = mkVec(0, 0, 4'd5,  4'd5,  0, 0, 16'h0020, 8'd1, 12'd1);
      vecs[3]  = mkVec(0, 0, 4'd5,  4'd5,  0, 0, 16'h0020, 8'd1, 12'd1);
      vecs[4]  = mkVec(0, 0, 4'd5,  4'd5,  0, 0, 16'h0020, 8'd1, 12'd1);
      vecs[5]  = mkVec(0, 0, 4'd5,  4'd5,  0, 0, 16'h0020, 8'd1, 12'd1);
      vecs[6]  = mkVec(0, 0, 4'd5,  4'd5,  0, 0, 16'h0000, 8'd1, 12'd1);
      vecs[7]  = mkVec(0, 0, 4'd5,  4'd5,  0, 0, 16'h0000, 8'd1, 12'd1);
      // Vote for 15 with the button held through RELEASE and a stray ballot_en.
      vecs[8]  = mkVec(1, 0, 4'd0,  4'd15, 1, 0, 16'h0000, 8'd0, 12'd1);
      vecs[9]  = mkVec(0, 1, 4'd15, 4'd15, 0, 1, 16'h8000, 8'd0, 12'd1);
      vecs[10] = mkVec(0, 1, 4'd15, 4'd15, 0, 0, 16'h8000, 8'd1, 12'd2);
      vecs[11] = mkVec(0, 1, 4'd15, 4'd15, 0, 0, 16'h8000, 8'd1, 12'd2);
      vecs[12] = mkVec(0, 1, 4'd15, 4'd15, 0, 0, 16'h8000, 8'd1, 12'd2);
      vecs[13] = mkVec(0, 1, 4'd15, 4'd15, 0, 0, 16'h8000, 8'd1, 12'd2);
      vecs[14] = mkVec(0, 1, 4'd15, 4'd15, 0, 0, 16'h0000, 8'd1, 12'd2);
      vecs[15] = mkVec(1, 1, 4'd15, 4'd15, 0, 0, 16'h0000, 8'd1, 12'd2);
      vecs[16] = mkVec(0, 1, 4'd15, 4'd15, 0, 0, 16'h0000, 8'd1, 12'd2);
      vecs[17] = mkVec(0, 0, 4'd15, 4'd15, 0, 0, 16'h0000, 8'd1, 12'd2);
      // Pre-pressed button blocks arming.
      vecs[18] = mkVec(1, 1, 4'd3,  4'd3,  0, 0, 16'h0000, 8'd0, 12'd2);
      vecs[19] = mkVec(1, 1, 4'd3,  4'd3,  0, 0, 16'h0000, 8'd0, 12'd2);
      vecs[20] = mkVec(0, 0, 4'd3,  4'd3,  0, 0, 16'h0000, 8'd0, 12'd2);
      vecs[21] = mkVec(1, 0, 4'd3,  4'd3,  1, 0, 16'h0000, 8'd0, 12'd2);
      // Code changes from 2 to 9 right after acceptance.
      vecs[22] = mkVec(0, 1, 4'd2,  4'd2,  0, 1, 16'h0004, 8'd0, 12'd2);
      vecs[23] = mkVec(0, 1, 4'd9,  4'd2,  0, 0, 16'h0004, 8'd1, 12'd3);
      vecs[24] = mkVec(0, 1, 4'd9,  4'd9,  0, 0, 16'h0004, 8'd0, 12'd3);
      vecs[25] = mkVec(0, 1, 4'd9,  4'd3,  0, 0, 16'h0004, 8'd0, 12'd3);
      vecs[26] = mkVec(0, 1, 4'd9,  4'd9,  0, 0, 16'h0004, 8'd0, 12'd3);
      vecs[27] = mkVec(0, 0, 4'd9,  4'd9,  0, 0, 16'h0000, 8'd0, 12'd3);
      vecs[28] = mkVec(0, 0, 4'd9,  4'd2,  0, 0, 16'h0000, 8'd1, 12'd3);

      #12;
      checkOutput("reset.busy",     {31'd0, busy},       32'd1);
      checkOutput("reset.ready",    {31'd0, ready},      32'd0);
      checkOutput("reset.strobe",   {31'd0, voteStrobe}, 32'd0);
      checkOutput("reset.onehot",   {16'd0, voteOnehot}, 32'd0);
      checkOutput("reset.total",    {20'd0, totalVotes}, 32'd0);
      checkOutput("reset.overflow", {31'd0, overflow},   32'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 29; i++) applyStimulus(vecs[i], i);
      checkOutput("main.overflow", {31'd0, overflow}, 32'd0);

      // Narrow counters: tally saturates at 3, overflow sets on the 4th vote.
      rdSel2 = 4'd0;
      for (int n = 1; n <= 5; n++) begin
         castNarrow(4'd0);
         checkOutput($sformatf("sat%0d.rdCount", n), {30'd0, rdCount2},    (n > 3) ? 32'd3 : n);
         checkOutput($sformatf("sat%0d.total", n),   {26'd0, totalVotes2}, n);
         checkOutput($sformatf("sat%0d.overflow", n),{31'd0, overflow2},   (n >= 4) ? 32'd1 : 32'd0);
         checkOutput($sformatf("sat%0d.ready", n),   {31'd0, ready2},      32'd0);
      end

      // Asynchronous reset in the middle of SHOW.
      @(negedge clk); ballotEn = 1'b1; valid = 1'b0;
      @(negedge clk); ballotEn = 1'b0; valid = 1'b1; code = 4'd7; rdSel = 4'd7;
      @(negedge clk); valid = 1'b0;
      @(posedge clk); @(posedge clk);
      #3;
      checkOutput("preRst.onehot",  {16'd0, voteOnehot}, 32'h0080);
      checkOutput("preRst.rdCount", {24'd0, rdCount},    32'd1);
      checkOutput("preRst.total",   {20'd0, totalVotes}, 32'd4);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRst.onehot",   {16'd0, voteOnehot}, 32'd0);
      checkOutput("asyncRst.rdCount",  {24'd0, rdCount},    32'd0);
      checkOutput("asyncRst.total",    {20'd0, totalVotes}, 32'd0);
      checkOutput("asyncRst.busy",     {31'd0, busy},       32'd1);
      checkOutput("asyncRst.ready",    {31'd0, ready},      32'd0);
      checkOutput("asyncRst.narrowOv", {31'd0, overflow2},  32'd0);
      rdSel = 4'd5;
      #1;
      checkOutput("asyncRst.count5",   {24'd0, rdCount},    32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("postRst.ready",     {31'd0, ready},      32'd0);
      checkOutput("postRst.onehot",    {16'd0, voteOnehot}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
